// File: rtl/ssp_fifo_if.sv
// SSP FIFO bus: push/pop requests, data and status.
// master = producer/consumer side, slave = the FIFO.
interface ssp_fifo_if #(
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
);
  logic             PUSH;
  logic [WIDTH-1:0] PUSH_DATA;
  logic             POP;
  logic [WIDTH-1:0] POP_DATA;
  logic             FULL;
  logic             EMPTY;
  logic [PTR_W:0]   COUNT;
  logic             INTR;
  logic             OVERFLOW;
  logic             UNDERFLOW;
  logic             ERR_CLR;

  modport master (
    output PUSH, PUSH_DATA, POP, ERR_CLR,
    input  POP_DATA, FULL, EMPTY, COUNT,
    input  INTR, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  PUSH, PUSH_DATA, POP, ERR_CLR,
    output POP_DATA, FULL, EMPTY, COUNT,
    output INTR, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/ssp_fifo.sv
// ssp_fifo: first-word fall-through byte FIFO between APB and SSP shifter.
// Ports: PCLK, CLEAR (async high), bus (ssp_fifo_if.slave).
module ssp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic PCLK,
  input logic CLEAR,
  ssp_fifo_if.slave bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;
  logic             r_udf;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_push_rej;
  logic w_pop_rej;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A pop frees the head slot, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign w_pop_ok   = bus.POP & ~w_empty;
  assign w_push_ok  = bus.PUSH & (~w_full | w_pop_ok);
  assign w_push_rej = bus.PUSH & ~w_push_ok;
  assign w_pop_rej  = bus.POP & ~w_pop_ok;

  always_ff @(posedge PCLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= bus.PUSH_DATA;
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)
        r_count <= r_count + 1'b1;
      else if (w_pop_ok && !w_push_ok)
        r_count <= r_count - 1'b1;
      // A new error outranks a same-cycle clear.
      r_ovf <= w_push_rej | (r_ovf & ~bus.ERR_CLR);
      r_udf <= w_pop_rej | (r_udf & ~bus.ERR_CLR);
    end
  end

  assign bus.POP_DATA  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.FULL      = w_full;
  assign bus.EMPTY     = w_empty;
  assign bus.COUNT     = r_count;
  assign bus.INTR      = w_full;
  assign bus.OVERFLOW  = r_ovf;
  assign bus.UNDERFLOW = r_udf;
endmodule

// File: tb/tb_ssp_fifo.sv
// tb_ssp_fifo: queue-model scoreboard plus directed checks for ssp_fifo.
// Ports: none (top-level bench).
module tb_ssp_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic PCLK = 1'b0;
  logic CLEAR;
  int   checks = 0;
  int   errors = 0;

  ssp_fifo_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

  ssp_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) dut (
    .PCLK (PCLK),
    .CLEAR(CLEAR),
    .bus  (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics.
  always @(posedge CLEAR) begin
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  end

  always @(posedge PCLK) begin
    if (CLEAR === 1'b0) begin
      bit pop_ok, push_ok;
      pop_ok  = bus.POP && m_q.size() > 0;
      push_ok = bus.PUSH && (m_q.size() < DEPTH || pop_ok);
      if (pop_ok)  void'(m_q.pop_front());
      if (push_ok) m_q.push_back(bus.PUSH_DATA);
      if (bus.PUSH && !push_ok)  m_ovf = 1'b1;
      else if (bus.ERR_CLR)      m_ovf = 1'b0;
      if (bus.POP && !pop_ok)    m_udf = 1'b1;
      else if (bus.ERR_CLR)      m_udf = 1'b0;
    end
  end

  always @(negedge PCLK) begin
    if (CLEAR === 1'b0) begin
      int n;
      n = m_q.size();
      chk("m_count", int'(bus.COUNT), n);
      chk("m_empty", int'(bus.EMPTY), int'(n == 0));
      chk("m_full",  int'(bus.FULL),  int'(n == DEPTH));
      chk("m_intr",  int'(bus.INTR),  int'(n == DEPTH));
      chk("m_data",  int'(bus.POP_DATA), n == 0 ? 0 : int'(m_q[0]));
      chk("m_ovf",   int'(bus.OVERFLOW),  int'(m_ovf));
      chk("m_udf",   int'(bus.UNDERFLOW), int'(m_udf));
    end
  end

  task automatic step(input bit p, input logic [7:0] d,
                      input bit q, input bit e);
    bus.PUSH      = p;
    bus.PUSH_DATA = d;
    bus.POP       = q;
    bus.ERR_CLR   = e;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] fl2 [4];
    fill = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    fl2  = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.PUSH = 0; bus.PUSH_DATA = 0; bus.POP = 0; bus.ERR_CLR = 0;
    CLEAR = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_empty", int'(bus.EMPTY), 1);
    chk("rst_count", int'(bus.COUNT), 0);
    chk("rst_data",  int'(bus.POP_DATA), 0);
    chk("rst_full",  int'(bus.FULL), 0);
    CLEAR = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step(1, fill[i], 0, 0);
      chk("fill_count", int'(bus.COUNT), i + 1);
      chk("fill_head",  int'(bus.POP_DATA), 'hA1);
    end
    chk("fill_full", int'(bus.FULL), 1);
    chk("fill_intr", int'(bus.INTR), 1);

    step(1, 8'hEE, 0, 0);
    chk("ovf_flag",  int'(bus.OVERFLOW), 1);
    chk("ovf_count", int'(bus.COUNT), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", int'(bus.POP_DATA), int'(fill[i]));
      step(0, 0, 1, 0);
    end
    chk("drain_empty", int'(bus.EMPTY), 1);
    chk("drain_data0", int'(bus.POP_DATA), 0);

    step(0, 0, 1, 0);
    chk("udf_flag",  int'(bus.UNDERFLOW), 1);
    chk("udf_count", int'(bus.COUNT), 0);
    step(0, 0, 0, 1);
    chk("errclr_udf", int'(bus.UNDERFLOW), 0);
    chk("errclr_ovf", int'(bus.OVERFLOW), 0);
    step(0, 0, 0, 0);

    step(1, 8'h00, 0, 0);
    for (int i = 1; i < 10; i++) begin
      chk("wrap_head", int'(bus.POP_DATA), i - 1);
      step(1, 8'(i), 1, 0);
      chk("wrap_count", int'(bus.COUNT), 1);
    end
    chk("wrap_last", int'(bus.POP_DATA), 9);
    step(0, 0, 1, 0);
    chk("wrap_empty", int'(bus.EMPTY), 1);

    for (int i = 0; i < 4; i++) step(1, fl2[i], 0, 0);
    chk("sf_head", int'(bus.POP_DATA), 'h11);
    step(1, 8'h55, 1, 0);
    chk("sf_count", int'(bus.COUNT), 4);
    chk("sf_ovf",   int'(bus.OVERFLOW), 0);
    chk("sf_full",  int'(bus.FULL), 1);
    chk("sf_head2", int'(bus.POP_DATA), 'h22);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("sf_tail", int'(bus.POP_DATA), 'h55);
    step(0, 0, 1, 0);
    chk("sf_empty", int'(bus.EMPTY), 1);

    step(1, 8'h77, 1, 0);
    chk("se_count", int'(bus.COUNT), 1);
    chk("se_data",  int'(bus.POP_DATA), 'h77);
    chk("se_udf",   int'(bus.UNDERFLOW), 1);

    step(1, 8'h78, 0, 1);
    step(1, 8'h79, 0, 0);
    chk("ar_pre", int'(bus.COUNT), 3);
    step(0, 0, 0, 0);
    #2 CLEAR = 1'b1;
    #1;
    chk("ar_empty", int'(bus.EMPTY), 1);
    chk("ar_count", int'(bus.COUNT), 0);
    chk("ar_data",  int'(bus.POP_DATA), 0);
    #1 CLEAR = 1'b0;
    step(1, 8'h3C, 0, 0);
    chk("ar_push", int'(bus.POP_DATA), 'h3C);
    chk("ar_cnt1", int'(bus.COUNT), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
